// File: rtl/masked_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// masked_serial_adder_ctrl
//
// Bit-serial, Boolean-masked W-bit ripple-carry adder. A single masked
// half-adder gadget (adder_1bit) is reused twice per bit:
//   HA1: (s1, c1) = HA(a_i, b_i)
//   HA2: (sum_i, c2) = HA(s1, c);  c <= c1 ^ c2
// c1 and c2 can never both be 1, so their OR is a plain sharewise XOR.
// This keeps the carry merge free of any extra masked gate.
//
// Ports (d shares, share j of bit i at index i*d+j):
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   a_in   in   [d*W]          operand A shares
//   b_in   in   [d*W]          operand B shares
//   cin    in   [d]            carry-in shares
//   rnd    in   [d*(d-1)/2]    fresh randomness, forwarded to the gadget
//   busy   out  high while the bit-serial datapath is working
//   done   out  one-cycle pulse, sum/cout valid
//   sum    out  [d*W]          result shares
//   cout   out  [d]            carry-out shares
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// adder_1bit
//
// Masked half-adder with LAT cycles of input-to-output latency (LAT >= 2).
// s = x ^ y (sharewise), c = x & y computed as a domain-oriented AND: each
// cross-domain product x_i*y_j is blinded with one random bit shared by the
// pair (i,j). It is registered before being compressed into share i.
//   clk, rst_n   clock / async active-low reset
//   x, y   [D]            input shares
//   rnd    [D*(D-1)/2]    fresh randomness, consumed on the last stage
//   s, c   [D]            xor / and output shares
// ---------------------------------------------------------------------------
module adder_1bit #(
    parameter int D   = 2,
    parameter int LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [D-1:0]          x,
    input  logic [D-1:0]          y,
    input  logic [D*(D-1)/2-1:0]  rnd,
    output logic [D-1:0]          s,
    output logic [D-1:0]          c
);
    // Input delay line; its last entry feeds the product stage.
    logic [D-1:0] x_pipe_q [LAT-1];
    logic [D-1:0] x_pipe_d [LAT-1];
    logic [D-1:0] y_pipe_q [LAT-1];
    logic [D-1:0] y_pipe_d [LAT-1];
    logic [D-1:0] x_last;
    logic [D-1:0] y_last;
    logic [D-1:0] s_q;
    logic [D-1:0] s_d;
    // prod[i][j]: diagonal holds the inner-domain product x_i*y_i,
    // off-diagonal holds x_i*y_j blinded with the pair's random bit.
    logic [D-1:0] prod_q [D];
    logic [D-1:0] prod_d [D];

    assign x_last = x_pipe_q[LAT-2];
    assign y_last = y_pipe_q[LAT-2];

    always_comb begin
        x_pipe_d[0] = x;
        y_pipe_d[0] = y;
        for (int k = 1; k < LAT-1; k++) begin
            x_pipe_d[k] = x_pipe_q[k-1];
            y_pipe_d[k] = y_pipe_q[k-1];
        end
        s_d = x_last ^ y_last;
    end

    for (genvar gi = 0; gi < D; gi++) begin : g_row
        for (genvar gj = 0; gj < D; gj++) begin : g_col
            if (gi == gj) begin : g_inner
                assign prod_d[gi][gj] = x_last[gi] & y_last[gi];
            end else begin : g_cross
                localparam int LO   = (gi < gj) ? gi : gj;
                localparam int HI   = (gi < gj) ? gj : gi;
                // Index of the unordered pair (LO,HI) in the packed rnd bus.
                localparam int RIDX = LO*D - (LO*(LO+1))/2 + (HI-LO-1);
                assign prod_d[gi][gj] = (x_last[gi] & y_last[gj]) ^ rnd[RIDX];
            end
        end
        // Compression happens only after the blinded terms are registered.
        assign c[gi] = ^prod_q[gi];
    end

    assign s = s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT-1; k++) begin
                x_pipe_q[k] <= '0;
                y_pipe_q[k] <= '0;
            end
            for (int i = 0; i < D; i++) begin
                prod_q[i] <= '0;
            end
            s_q <= '0;
        end else begin
            x_pipe_q <= x_pipe_d;
            y_pipe_q <= y_pipe_d;
            prod_q   <= prod_d;
            s_q      <= s_d;
        end
    end
endmodule

module masked_serial_adder_ctrl #(
    parameter int d   = 2,
    parameter int W   = 8,
    parameter int LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [d*W-1:0]        a_in,
    input  logic [d*W-1:0]        b_in,
    input  logic [d-1:0]          cin,
    input  logic [d*(d-1)/2-1:0]  rnd,
    output logic                  busy,
    output logic                  done,
    output logic [d*W-1:0]        sum,
    output logic [d-1:0]          cout
);
    localparam int PH_W  = $clog2(LAT + 1);
    localparam int BIT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HA1  = 2'd1,
        HA2  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [BIT_W-1:0]    bit_q,   bit_d;
    logic [d*W-1:0]      a_q,     a_d;
    logic [d*W-1:0]      b_q,     b_d;
    logic [d-1:0]        c_q,     c_d;      // running carry shares
    logic [d-1:0]        s1_q,    s1_d;     // HA1 xor result
    logic [d-1:0]        c1_q,    c1_d;     // HA1 and result
    logic [d*W-1:0]      sum_q,   sum_d;
    logic [d-1:0]        cout_q,  cout_d;

    logic [d-1:0]        gad_x, gad_y, gad_s, gad_c;
    logic [d-1:0]        a_bit, b_bit;
    logic                phase_last;
    logic                bit_last;

    adder_1bit #(
        .D   (d),
        .LAT (LAT)
    ) u_ha (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (gad_x),
        .y     (gad_y),
        .rnd   (rnd),
        .s     (gad_s),
        .c     (gad_c)
    );

    // Current bit's shares, selected with constant slices only.
    always_comb begin
        a_bit = '0;
        b_bit = '0;
        for (int i = 0; i < W; i++) begin
            if (bit_q == BIT_W'(i)) begin
                a_bit = a_q[i*d +: d];
                b_bit = b_q[i*d +: d];
            end
        end
    end

    assign phase_last = (phase_q == PH_W'(LAT));
    assign bit_last   = (bit_q == BIT_W'(W - 1));

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        s1_d    = s1_q;
        c1_d    = c1_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        gad_x   = '0;
        gad_y   = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    c_d     = cin;
                    bit_d   = '0;
                    phase_d = '0;
                    sum_d   = '0;
                    cout_d  = '0;
                    state_d = HA1;
                end
            end
            HA1: begin
                gad_x = a_bit;
                gad_y = b_bit;
                if (phase_last) begin
                    s1_d    = gad_s;
                    c1_d    = gad_c;
                    phase_d = '0;
                    state_d = HA2;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            HA2: begin
                gad_x = s1_q;
                gad_y = c_q;
                if (phase_last) begin
                    for (int i = 0; i < W; i++) begin
                        if (bit_q == BIT_W'(i)) begin
                            sum_d[i*d +: d] = gad_s;
                        end
                    end
                    c_d     = c1_q ^ gad_c;
                    phase_d = '0;
                    if (bit_last) begin
                        cout_d  = c1_q ^ gad_c;
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = HA1;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            s1_q    <= '0;
            c1_q    <= '0;
            sum_q   <= '0;
            cout_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            s1_q    <= s1_d;
            c1_q    <= c1_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == HA1) || (state_q == HA2);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_masked_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_masked_serial_adder_ctrl
//
// Two instances: d=2/W=4 for directed table vectors and multi-cycle corner
// cases, d=3/W=8 for randomized operations against plain integer addition.
// Operands are shared randomly; results are recombined by XOR of shares.
// ---------------------------------------------------------------------------
module tb_masked_serial_adder_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // d=2, W=4 instance
    logic        rst_n2;
    logic        start2;
    logic [7:0]  a_in2, b_in2;
    logic [1:0]  cin2;
    logic [0:0]  rnd2;
    logic        busy2, done2;
    logic [7:0]  sum2;
    logic [1:0]  cout2;

    // d=3, W=8 instance
    logic        rst_n3;
    logic        start3;
    logic [23:0] a_in3, b_in3;
    logic [2:0]  cin3;
    logic [2:0]  rnd3;
    logic        busy3, done3;
    logic [23:0] sum3;
    logic [2:0]  cout3;

    masked_serial_adder_ctrl #(.d(2), .W(4), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n2), .start(start2), .a_in(a_in2), .b_in(b_in2),
        .cin(cin2), .rnd(rnd2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    masked_serial_adder_ctrl #(.d(3), .W(8), .LAT(2)) dut3 (
        .clk(clk), .rst_n(rst_n3), .start(start3), .a_in(a_in3), .b_in(b_in3),
        .cin(cin3), .rnd(rnd3), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    // Fresh randomness every cycle.
    always @(negedge clk) begin
        rnd2 = 1'($urandom);
        rnd3 = 3'($urandom);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Random Boolean sharing of v: share dd-1 of each bit completes the XOR.
    function automatic logic [23:0] share_word(input int dd, input int ww, input logic [7:0] v);
        logic [23:0] r;
        logic        acc;
        logic        rb;
        r = '0;
        for (int i = 0; i < ww; i++) begin
            acc = v[i];
            for (int j = 0; j < dd - 1; j++) begin
                rb = 1'($urandom);
                r[i*dd+j] = rb;
                acc = acc ^ rb;
            end
            r[i*dd+dd-1] = acc;
        end
        return r;
    endfunction

    function automatic logic [7:0] unshare(input int dd, input int ww, input logic [23:0] s);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < ww; i++)
            for (int j = 0; j < dd; j++)
                v[i] = v[i] ^ s[i*dd+j];
        return v;
    endfunction

    function automatic logic [7:0] share_of(input int dd, input int ww, input logic [23:0] s, input int j);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < ww; i++) v[i] = s[i*dd+j];
        return v;
    endfunction

    // One d=2 operation; operands are scrambled and a stray start is pulsed
    // while busy, neither of which may affect the result.
    task automatic run2(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        output logic [3:0] s, output logic co, output int cyc, output int bcnt);
        logic [23:0] t;
        logic [7:0]  v;
        @(negedge clk);
        t = share_word(2, 4, {4'h0, a}); a_in2 = t[7:0];
        t = share_word(2, 4, {4'h0, b}); b_in2 = t[7:0];
        t = share_word(2, 1, {7'h0, ci}); cin2 = t[1:0];
        start2 = 1'b1;
        cyc  = 0;
        bcnt = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy2) bcnt++;
            if (done2) break;
            if (cyc == 1) begin
                start2 = 1'b0;
                a_in2  = 8'($urandom);
                b_in2  = 8'($urandom);
                cin2   = 2'($urandom);
            end
            if (cyc == 10) start2 = 1'b1;
            if (cyc == 11) start2 = 1'b0;
        end
        start2 = 1'b0;
        t  = {16'h0, sum2};
        v  = unshare(2, 4, t);
        s  = v[3:0];
        co = ^cout2;
    endtask

    task automatic run3(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output logic [23:0] s_raw, output logic [2:0] c_raw, output logic timed_out);
        logic [23:0] t;
        int cyc;
        @(negedge clk);
        a_in3 = share_word(3, 8, a);
        b_in3 = share_word(3, 8, b);
        t = share_word(3, 1, {7'h0, ci}); cin3 = t[2:0];
        start3 = 1'b1;
        cyc = 0;
        timed_out = 1'b1;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done3) begin
                timed_out = 1'b0;
                break;
            end
            if (cyc == 1) begin
                start3 = 1'b0;
                a_in3  = 24'($urandom);
                b_in3  = 24'($urandom);
                cin3   = 3'($urandom);
            end
        end
        start3 = 1'b0;
        s_raw = sum3;
        c_raw = cout3;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [3:0]  s4;
        logic        co;
        int          cyc, bcnt, ndone;
        logic [23:0] t, s_raw;
        logic [2:0]  c_raw;
        logic        to;
        logic [7:0]  a8, b8, v;
        logic        ci;
        logic [8:0]  exp9;
        logic [2:0]  differs;

        vecs[0] = '{4'hB, 4'h6, 1'b0, 4'h1, 1'b1};
        vecs[1] = '{4'hB, 4'h6, 1'b1, 4'h2, 1'b1};
        vecs[2] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        vecs[3] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
        vecs[4] = '{4'h5, 4'h3, 1'b0, 4'h8, 1'b0};
        vecs[5] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        vecs[6] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0};
        vecs[7] = '{4'h9, 4'h9, 1'b1, 4'h3, 1'b1};

        rst_n2 = 1'b0; start2 = 1'b0; a_in2 = '0; b_in2 = '0; cin2 = '0;
        rst_n3 = 1'b0; start3 = 1'b0; a_in3 = '0; b_in3 = '0; cin3 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'h0, busy2}, 0);
        check("reset_done", {31'h0, done2}, 0);
        check("reset_sum",  {24'h0, sum2}, 0);
        check("reset_cout", {30'h0, cout2}, 0);
        rst_n2 = 1'b1;
        rst_n3 = 1'b1;

        // Table-driven vectors on the d=2, W=4 instance.
        for (int k = 0; k < 8; k++) begin
            run2(vecs[k].a, vecs[k].b, vecs[k].ci, s4, co, cyc, bcnt);
            check("vec_sum",        {28'h0, s4}, {28'h0, vecs[k].sum});
            check("vec_cout",       {31'h0, co}, {31'h0, vecs[k].cout});
            check("vec_done_cycle", cyc, 25);
            check("vec_busy_cycles", bcnt, 24);
            $display("vec %0d: A=%h B=%h cin=%0d -> sum=%h cout=%0d done@%0d busy=%0d",
                     k, vecs[k].a, vecs[k].b, vecs[k].ci, s4, co, cyc, bcnt);
        end

        // Asynchronous reset during HA2 of bit 2 (cycles 16..18 after start).
        @(negedge clk);
        t = share_word(2, 4, 8'h0B); a_in2 = t[7:0];
        t = share_word(2, 4, 8'h06); b_in2 = t[7:0];
        cin2 = 2'b00;
        start2 = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 1) start2 = 1'b0;
        end
        #1 rst_n2 = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy2}, 0);
        check("abort_done", {31'h0, done2}, 0);
        check("abort_sum",  {24'h0, sum2}, 0);
        check("abort_cout", {30'h0, cout2}, 0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 2) rst_n2 = 1'b1;
            if (done2) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run2(4'hF, 4'h1, 1'b0, s4, co, cyc, bcnt);
        check("post_reset_sum",  {28'h0, s4}, 0);
        check("post_reset_cout", {31'h0, co}, 1);
        $display("after reset: A=f B=1 -> sum=%h cout=%0d done@%0d", s4, co, cyc);

        // start held high: back-to-back operations, none taken while busy or in DONE.
        @(negedge clk);
        t = share_word(2, 4, 8'h05); a_in2 = t[7:0];
        t = share_word(2, 4, 8'h03); b_in2 = t[7:0];
        cin2 = 2'b00;
        start2 = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 26) check("held_idle_gap_busy", {31'h0, busy2}, 0);
            if (c == 27) check("held_second_accept", {31'h0, busy2}, 1);
            if (done2) begin
                ndone++;
                check("held_done_cycle", c, (ndone == 1) ? 25 : 51);
                t = {16'h0, sum2};
                v = unshare(2, 4, t);
                check("held_sum",  {24'h0, v}, 8);
                check("held_cout", {31'h0, ^cout2}, 0);
                $display("held start op %0d: sum=%h cout=%0d done@%0d", ndone, v[3:0], ^cout2, c);
            end
        end
        start2 = 1'b0;
        check("held_done_count", ndone, 2);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done2) break;
        end

        // Randomized operations on the d=3, W=8 instance.
        differs = '0;
        for (int n = 0; n < 1000; n++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            ci = 1'($urandom);
            run3(a8, b8, ci, s_raw, c_raw, to);
            v    = unshare(3, 8, s_raw);
            exp9 = 9'(a8) + 9'(b8) + 9'(ci);
            check("rand_result", {22'h0, to, ^c_raw, v}, {22'h0, 1'b0, exp9});
            for (int j = 0; j < 3; j++)
                if (share_of(3, 8, s_raw, j) != v) differs[j] = 1'b1;
            $display("rand %0d: A=%h B=%h cin=%0d -> cout=%0d sum=%h", n, a8, b8, ci, ^c_raw, v);
        end
        for (int j = 0; j < 3; j++)
            check("share_differs", {31'h0, differs[j]}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/masked_serial_adder_ctrl.md
Name: masked_serial_adder_ctrl

Overview:
- Bit-serial W-bit masked ripple-carry adder built around one shared adder_1bit (masked half-adder) gadget, time-multiplexed between the two half-adder steps of each full-adder bit.
- Sequences the gadget, feeds the carry back, and assembles the shared sum.
- Serves as the low-area masked addition/carry unit for the decapsulation datapath, where throughput is not critical.

Parameters:
- d, 2, number of Boolean shares (masking order + 1).
- W, 8, operand width in bits.
- LAT, 2, gadget input-to-output latency in cycles (fixed by the half-adder gadget).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  d*W  operand A shares; bit i share j at index i*d+j.
- b_in  in  d*W  operand B shares; same layout.
- cin  in  d  carry-in shares.
- rnd  in  d*(d-1)/2  fresh randomness, forwarded to the gadget; must be fresh every cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; sum and cout valid.
- sum  out  d*W  result shares; same layout as a_in.
- cout  out  d  carry-out shares.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; busy=0, done=0; sum, cout, carry and all operand/intermediate registers cleared to 0.
  - Asserting reset mid-operation aborts the operation with no done.
- IDLE:
  - When start=1: latch a_in, b_in, cin into internal registers; bit index i=0; carry register c=cin; go to HA1.
  - Inputs are not sampled again until the next accepted start.
  - While busy, start is ignored.
- HA1 (LAT+1 cycles, phase counter 0..LAT):
  - Gadget inputs held at a_i, b_i for the whole phase.
  - On the final edge capture s1 = gadget xor output and c1 = gadget and output; go to HA2.
- HA2 (LAT+1 cycles):
  - Gadget inputs held at s1, c.
  - On the final edge write sum bit i = gadget xor output, and c = c1 XOR gadget and output (sharewise).
  - XOR is correct because c1 and c2 are mutually exclusive; no randomness is needed.
  - If i=W-1: cout=c, go to DONE. Otherwise i=i+1, go to HA1.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start arriving in DONE is ignored.
- Timing:
  - Latency: start sampled at edge e0; done=1 during the cycle after edge e0 + W*2*(LAT+1).
  - For W=4, LAT=2: done is high in the 25th cycle after the start cycle.
  - busy=1 for exactly W*2*(LAT+1) cycles.
- Output stability:
  - sum and cout hold their last values until the next start is accepted, or until reset.
  - sum bits are written progressively during an operation; only the values at done are defined.
- Gadget inputs when not in HA1/HA2: all-zero shares. rnd is forwarded unconditionally.
- Masking rules:
  - Never combine shares of the same bit: all XORs are sharewise.
  - No unmasked value appears on any wire or register.
  - Phase counter and bit index are the only unshared state.
- W=1 is legal: HA1, HA2, DONE.
- No wrap-around of i beyond W-1.

Test Plan:
- d=2, W=4; A=0xB, B=0x6, cin=0; random shares and random rnd every cycle -> at done: XOR-unshared sum=0x1, cout=1; done high exactly 25 cycles after the start cycle; busy high for 24 cycles.
- Same operands with cin=1 -> sum=0x2, cout=1. A=0x0, B=0x0, cin=0 -> sum=0x0, cout=0.
- Reset: assert rst_n=0 during HA2 of bit 2 -> busy, done, sum and cout are 0 immediately (asynchronously); after release, a new start with A=0xF, B=0x1 -> sum=0x0, cout=1.
- Start held high continuously for 60 cycles with A=0x5, B=0x3:
  - Two back-to-back operations, each giving sum=0x8, cout=0.
  - The second start is accepted in the IDLE cycle following DONE.
  - No start is taken while busy.
- Operand inputs changed while busy -> result reflects the operands latched at start.
- Randomized: d=3, W=8, 1000 operations with random operands, shares and rnd -> unshared {cout,sum} equals A+B+cin every time; each share of sum differs from its unshared value in at least one operation.
